// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C_Driver between two requesters; the owner keeps the bus until it drops req.
// Optional hold-time watchdog with lockout is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned TO_W           = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       ena0,
  input  logic       rw0,
  input  logic       start0,
  input  logic       stop0,
  input  logic       rstart0,
  input  logic [7:0] data_wr0,
  output logic [7:0] data_rd0,
  output logic       busy0,
  output logic       ready0,
  output logic       ack_err0,
  input  logic       ena1,
  input  logic       rw1,
  input  logic       start1,
  input  logic       stop1,
  input  logic       rstart1,
  input  logic [7:0] data_wr1,
  output logic [7:0] data_rd1,
  output logic       busy1,
  output logic       ready1,
  output logic       ack_err1,
  output logic       m_ena,
  output logic       m_rw,
  output logic       m_start_transfer,
  output logic       m_stop_transfer,
  output logic       m_r_start,
  output logic [7:0] m_data_wr,
  input  logic [7:0] m_data_rd,
  input  logic       m_busy,
  input  logic       m_ready,
  input  logic       m_ack_err,
  output logic       owner,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN, RELEASE} state_t;

  state_t     state_q, state_d;
  logic       owner_d;
  logic       rr_q, rr_d;
  logic       timeout_d;
  logic       to_hit;
  logic [1:0] locked;
  logic       elig0, elig1, req_own;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  // Hold-time counter: zero on grant, counts every cycle spent in OWN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state_q == IDLE && state_d == OWN) begin
      to_cnt <= '0;
    end else if (state_q == OWN) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign to_hit = (state_q == OWN) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // An offender stays locked out until its request is seen low at an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 2'b00;
    end else begin
      if (timeout_d && !owner)     locked[0] <= 1'b1;
      else if (!req0)              locked[0] <= 1'b0;
      if (timeout_d && owner)      locked[1] <= 1'b1;
      else if (!req1)              locked[1] <= 1'b0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TO_W'(TIMEOUT_CYCLES);
  assign to_hit     = 1'b0;
  assign locked     = 2'b00;
`endif

  assign elig0   = req0 && !locked[0];
  assign elig1   = req1 && !locked[1];
  assign req_own = owner ? req1 : req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner       <= 1'b0;
      rr_q        <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner       <= owner_d;
      rr_q        <= rr_d;
      gnt0        <= (state_d == OWN) && !owner_d;
      gnt1        <= (state_d == OWN) && owner_d;
      timeout_err <= timeout_d;
    end
  end

  // Next-state: grant, release on req drop, drain an abandoned transfer
  always_comb begin
    state_d   = state_q;
    owner_d   = owner;
    rr_d      = rr_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (elig0 && elig1)  owner_d = rr_q;
        else if (elig0)      owner_d = 1'b0;
        else if (elig1)      owner_d = 1'b1;
        if (elig0 || elig1) begin
          state_d = OWN;
          rr_d    = !owner_d;
        end
      end
      OWN: begin
        if (!req_own) begin
          state_d = m_busy ? DRAIN : RELEASE;
        end else if (to_hit) begin
          state_d   = DRAIN;
          timeout_d = 1'b1;
        end
      end
      DRAIN:   if (!m_busy) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus and status muxing: owner sees the driver, everyone else sees a busy bus
  always_comb begin
    m_ena            = 1'b0;
    m_rw             = 1'b0;
    m_start_transfer = 1'b0;
    m_stop_transfer  = 1'b0;
    m_r_start        = 1'b0;
    m_data_wr        = 8'h00;
    busy0            = 1'b1;
    ready0           = 1'b0;
    ack_err0         = 1'b0;
    data_rd0         = 8'h00;
    busy1            = 1'b1;
    ready1           = 1'b0;
    ack_err1         = 1'b0;
    data_rd1         = 8'h00;
    if (state_q == OWN) begin
      if (!owner) begin
        m_ena            = ena0;
        m_rw             = rw0;
        m_start_transfer = start0;
        m_stop_transfer  = stop0;
        m_r_start        = rstart0;
        m_data_wr        = data_wr0;
        busy0            = m_busy;
        ready0           = m_ready;
        ack_err0         = m_ack_err;
        data_rd0         = m_data_rd;
      end else begin
        m_ena            = ena1;
        m_rw             = rw1;
        m_start_transfer = start1;
        m_stop_transfer  = stop1;
        m_r_start        = rstart1;
        m_data_wr        = data_wr1;
        busy1            = m_busy;
        ready1           = m_ready;
        ack_err1         = m_ack_err;
        data_rd1         = m_data_rd;
      end
    end else if (state_q == DRAIN) begin
      m_stop_transfer = 1'b1;
    end
  end

endmodule
